// File: rtl/regbank_pkg.sv
// Shared types and default sizes for the general-purpose register bank.
package regbank_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } regbank_state_t;

  localparam int          REGBANK_XLEN     = 32;
  localparam int          REGBANK_NREGS    = 32;
  localparam logic [31:0] REGBANK_SP_RESET = 32'h3fc;

endpackage

// File: rtl/regbank_read_port.sv
// One combinational read port: index mux, x0 masking and zeroing until the bank is ready.
// Optional same-cycle write bypass when REGBANK_BYPASS_EN is defined.
module regbank_read_port #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic [NREGS*XLEN-1:0] regs_flat,
  input  logic [AW-1:0]         rs,
  input  logic                  ready,
  input  logic                  byp_valid,
  input  logic [AW-1:0]         byp_idx,
  input  logic [XLEN-1:0]       byp_data,
  output logic [XLEN-1:0]       rdata
);

`ifndef REGBANK_BYPASS_EN
  logic unused_byp;
  assign unused_byp = ^{byp_valid, byp_idx, byp_data};
`endif

  always_comb begin
    rdata = '0;
    if (ready && (rs != '0)) begin
      rdata = regs_flat[rs*XLEN +: XLEN];
`ifdef REGBANK_BYPASS_EN
      // byp_valid already excludes x0 and the not-ready window
      if (byp_valid && (byp_idx == rs)) begin
        rdata = byp_data;
      end
`endif
    end
  end

endmodule

// File: rtl/register_bank.sv
// Parametrised RISC-V register bank with post-reset clear sweep and ready/stall flag.
// Define REGBANK_BYPASS_EN to forward the writeback value to read ports in the same cycle.
module register_bank
  import regbank_pkg::*;
#(
  parameter int               XLEN       = REGBANK_XLEN,
  parameter int               NREGS      = REGBANK_NREGS,
  parameter int               READ_PORTS = 2,
  parameter int               SP_INDEX   = 2,
  parameter logic [XLEN-1:0]  SP_RESET   = XLEN'(REGBANK_SP_RESET)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 writeRegister,
  input  logic [$clog2(NREGS)-1:0]             rd,
  input  logic [XLEN-1:0]                      dataToWrite,
  input  logic [READ_PORTS*$clog2(NREGS)-1:0]  rs,
  output logic [READ_PORTS*XLEN-1:0]           registerRead,
  input  logic [$clog2(NREGS)-1:0]             watchRegister,
  output logic [XLEN-1:0]                      watchRegisterValue,
  output logic                                 ready,
  output logic                                 writeDropped
);

  localparam int AW = $clog2(NREGS);

  if (SP_INDEX <= 0 || SP_INDEX >= NREGS) begin : g_bad_sp_index
    $error("register_bank: SP_INDEX must lie in 1..NREGS-1");
  end
  if (READ_PORTS < 1 || READ_PORTS > 4) begin : g_bad_read_ports
    $error("register_bank: READ_PORTS must lie in 1..4");
  end

  regbank_state_t        state_q, state_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic                  ready_q, ready_d;
  logic                  write_dropped_q, write_dropped_d;

  logic                  wr_en;
  logic [AW-1:0]         wr_idx;
  logic [XLEN-1:0]       wr_data;

  logic [XLEN-1:0]       regs_q [NREGS];
  logic [NREGS*XLEN-1:0] regs_flat;
  logic                  byp_valid;

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    ready_d         = ready_q;
    write_dropped_d = 1'b0;
    wr_en           = 1'b0;
    wr_idx          = rd;
    wr_data         = dataToWrite;
    case (state_q)
      CLEAR: begin
        // the sweep owns the write port; any core write this cycle is lost
        wr_en           = !reset;
        wr_idx          = idx_q;
        wr_data         = (idx_q == AW'(SP_INDEX)) ? SP_RESET : '0;
        idx_d           = idx_q + 1'b1;
        write_dropped_d = writeRegister;
        if (idx_q == AW'(NREGS - 1)) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        wr_en = !reset && writeRegister && (rd != '0);
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= CLEAR;
      idx_q           <= '0;
      ready_q         <= 1'b0;
      write_dropped_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      ready_q         <= ready_d;
      write_dropped_q <= write_dropped_d;
    end
  end

  // storage is deliberately not reset: only the sweep initialises it
  always_ff @(posedge clock) begin
    if (wr_en) begin
      regs_q[wr_idx] <= wr_data;
    end
  end

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_flat
    assign regs_flat[gi*XLEN +: XLEN] = regs_q[gi];
  end

  assign byp_valid = ready_q && writeRegister && (rd != '0);

  for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_rd
    regbank_read_port #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_port (
      .regs_flat (regs_flat),
      .rs        (rs[gi*AW +: AW]),
      .ready     (ready_q),
      .byp_valid (byp_valid),
      .byp_idx   (rd),
      .byp_data  (dataToWrite),
      .rdata     (registerRead[gi*XLEN +: XLEN])
    );
  end

  regbank_read_port #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_watch (
    .regs_flat (regs_flat),
    .rs        (watchRegister),
    .ready     (ready_q),
    .byp_valid (1'b0),
    .byp_idx   (rd),
    .byp_data  (dataToWrite),
    .rdata     (watchRegisterValue)
  );

  assign ready        = ready_q;
  assign writeDropped = write_dropped_q;

endmodule

// File: tb/tb_register_bank.sv
// Randomised plus directed bench for register_bank against a behavioural model of the bank.
`timescale 1ns/1ps
module tb_register_bank;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int RP = 2;
  localparam int AW = 5;
  localparam int X2 = 64;
  localparam int N2 = 16;
  localparam int RP2 = 3;
  localparam int AW2 = 4;
`ifdef REGBANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic               we = 1'b0;
  logic [AW-1:0]      rd = '0;
  logic [XLEN-1:0]    wdata = '0;
  logic [RP*AW-1:0]   rs = '0;
  logic [RP*XLEN-1:0] rdata;
  logic [AW-1:0]      widx = '0;
  logic [XLEN-1:0]    wval;
  logic               ready, dropped;

  logic                we2 = 1'b0;
  logic [AW2-1:0]      rd2 = '0;
  logic [X2-1:0]       wdata2 = '0;
  logic [RP2*AW2-1:0]  rs2 = '0;
  logic [RP2*X2-1:0]   rdata2;
  logic [AW2-1:0]      widx2 = '0;
  logic [X2-1:0]       wval2;
  logic                ready2, dropped2;

  register_bank dut (
    .clock(clock), .reset(reset), .writeRegister(we), .rd(rd), .dataToWrite(wdata),
    .rs(rs), .registerRead(rdata), .watchRegister(widx), .watchRegisterValue(wval),
    .ready(ready), .writeDropped(dropped)
  );

  register_bank #(.XLEN(X2), .NREGS(N2), .READ_PORTS(RP2), .SP_INDEX(2), .SP_RESET(64'h3fc)) dut2 (
    .clock(clock), .reset(reset), .writeRegister(we2), .rd(rd2), .dataToWrite(wdata2),
    .rs(rs2), .registerRead(rdata2), .watchRegister(widx2), .watchRegisterValue(wval2),
    .ready(ready2), .writeDropped(dropped2)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: count reset-low edges; once NREGS have elapsed the bank is
  // ready and holds its initial image, then RUN writes apply to every index but x0.
  logic [XLEN-1:0] m_regs [NREGS];
  bit m_ready = 1'b0;
  int m_low_edges = 0;
  bit m_drop = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      m_ready = 1'b0;
      m_low_edges = 0;
      m_drop = 1'b0;
    end else if (!m_ready) begin
      m_drop = we;
      m_low_edges++;
      if (m_low_edges == NREGS) begin
        m_ready = 1'b1;
        for (int i = 0; i < NREGS; i++) m_regs[i] = (i == 2) ? 32'h3fc : 32'h0;
      end
    end else begin
      m_drop = 1'b0;
      if (we && rd != 0) m_regs[rd] = wdata;
    end
  end

  function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] idx, input bit allow_byp);
    if (!m_ready || idx == 0) return '0;
    if (allow_byp && BYP && we && rd != 0 && rd == idx) return wdata;
    return m_regs[idx];
  endfunction

  always @(negedge clock) begin
    if (cmp_en) begin
      check("ready", 64'(ready), 64'(m_ready));
      check("writeDropped", 64'(dropped), 64'(m_drop));
      for (int p = 0; p < RP; p++)
        check($sformatf("read_port%0d", p), 64'(rdata[p*XLEN +: XLEN]), 64'(exp_read(rs[p*AW +: AW], 1'b1)));
      check("watch", 64'(wval), 64'(exp_read(widx, 1'b0)));
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int waited;
    // sweep timing, with a write dropped at cycle 10
    cyc();
    cmp_en = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    for (int k = 1; k <= NREGS; k++) begin
      we = (k == 10);
      rd = 5'd3;
      wdata = 32'h55;
      cyc();
      we = 1'b0;
      if (k < NREGS) check("ready_low_during_sweep", 64'(ready), 64'd0);
      else           check("ready_after_32_edges", 64'(ready), 64'd1);
      if (k == 10) check("dropped_pulse", 64'(dropped), 64'd1);
      if (k == 11) check("dropped_one_cycle", 64'(dropped), 64'd0);
      if (k == N2 - 1) check("dut2_ready_low_15", 64'(ready2), 64'd0);
      if (k == N2) check("dut2_ready_16", 64'(ready2), 64'd1);
    end
    $display("txn sweep done ready=%0b", ready);

    rs = {5'd1, 5'd2};
    widx = 5'd31;
    @(negedge clock);
    check("x2_sp_reset", 64'(rdata[0 +: XLEN]), 64'h3fc);
    check("x1_zero", 64'(rdata[XLEN +: XLEN]), 64'h0);
    check("x31_zero", 64'(wval), 64'h0);
    cyc();
    widx = 5'd3;
    @(negedge clock);
    check("x3_after_drop", 64'(wval), 64'h0);
    cyc();

    // write then read on both ports
    we = 1'b1; rd = 5'd5; wdata = 32'hDEADBEEF;
    $display("txn write x5=%h", wdata);
    cyc();
    we = 1'b0; rs = {5'd5, 5'd5};
    @(negedge clock);
    check("x5_port0", 64'(rdata[0 +: XLEN]), 64'hDEADBEEF);
    check("x5_port1", 64'(rdata[XLEN +: XLEN]), 64'hDEADBEEF);
    cyc();
    we = 1'b1; rd = 5'd0; wdata = 32'h1234; rs = '0; widx = '0;
    $display("txn write x0=%h", wdata);
    cyc();
    we = 1'b0;
    @(negedge clock);
    check("x0_port0", 64'(rdata[0 +: XLEN]), 64'h0);
    check("x0_watch", 64'(wval), 64'h0);
    check("x0_no_drop", 64'(dropped), 64'h0);
    cyc();

    // same-cycle write/read of x7
    we = 1'b1; rd = 5'd7; wdata = 32'hA5A5A5A5; rs = {5'd7, 5'd0}; widx = 5'd7;
    $display("txn write x7=%h with read", wdata);
    @(negedge clock);
    check("bypass_port1", 64'(rdata[XLEN +: XLEN]), BYP ? 64'hA5A5A5A5 : 64'h0);
    check("watch_not_bypassed", 64'(wval), 64'h0);
    cyc();
    we = 1'b0;
    @(negedge clock);
    check("x7_after_write", 64'(rdata[XLEN +: XLEN]), 64'hA5A5A5A5);
    cyc();

    // wide instance: three simultaneous reads
    we2 = 1'b1; rd2 = 4'd1; wdata2 = 64'h1111_2222_3333_4444; cyc();
    rd2 = 4'd2; wdata2 = 64'h8000_0000_0000_0002; cyc();
    rd2 = 4'd15; wdata2 = 64'hFEDC_BA98_7654_3210; cyc();
    we2 = 1'b0; rs2 = {4'd15, 4'd2, 4'd1}; widx2 = 4'd2;
    $display("txn dut2 writes x1 x2 x15");
    @(negedge clock);
    check("dut2_x1", rdata2[0 +: X2], 64'h1111_2222_3333_4444);
    check("dut2_x2", rdata2[X2 +: X2], 64'h8000_0000_0000_0002);
    check("dut2_x15", rdata2[2*X2 +: X2], 64'hFEDC_BA98_7654_3210);
    check("dut2_watch_x2", wval2, 64'h8000_0000_0000_0002);
    check("dut2_no_drop", 64'(dropped2), 64'h0);
    cyc();

    // randomised traffic with occasional resets, checked by the model every cycle
    for (int t = 0; t < 200; t++) begin
      reset = ($urandom_range(0, 63) == 0);
      we = $urandom_range(0, 1);
      rd = AW'($urandom);
      wdata = $urandom;
      rs = (RP*AW)'($urandom);
      widx = AW'($urandom);
      $display("txn rand %0d rst=%0b we=%0b rd=%0d data=%h rs=%h watch=%0d",
               t, reset, we, rd, wdata, rs, widx);
      cyc();
    end
    reset = 1'b0;
    we = 1'b0;

    // reset from RUN
    waited = 0;
    while (!ready && waited < 2*NREGS) begin
      cyc();
      waited++;
    end
    check("ready_before_reset_test", 64'(ready), 64'd1);
    we = 1'b1; rd = 5'd4; wdata = 32'd9;
    $display("txn write x4=%h then reset", wdata);
    cyc();
    we = 1'b0; reset = 1'b1; rs = {5'd2, 5'd4}; widx = 5'd4;
    cyc();
    reset = 1'b0;
    @(negedge clock);
    check("reset_ready_low", 64'(ready), 64'd0);
    check("reset_port0_zero", 64'(rdata[0 +: XLEN]), 64'h0);
    check("reset_port1_zero", 64'(rdata[XLEN +: XLEN]), 64'h0);
    check("reset_watch_zero", 64'(wval), 64'h0);
    repeat (NREGS) cyc();
    @(negedge clock);
    check("resweep_ready", 64'(ready), 64'd1);
    check("resweep_x4", 64'(rdata[0 +: XLEN]), 64'h0);
    check("resweep_x2", 64'(rdata[XLEN +: XLEN]), 64'h3fc);
    cyc();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
